// File: rtl/ov7670_sccb_config.sv
// OV7670 boot sequencer: walks an external register table and issues one
// SCCB 3-phase write (ID, reg, val) per entry, honouring delay and end markers.
module ov7670_sccb_config #(
  parameter int          CLK_FREQ_HZ  = 50_000_000,
  parameter int          SCCB_FREQ_HZ = 100_000,
  parameter logic [7:0]  DEV_ID       = 8'h42,
  parameter int          DELAY_CYCLES = 500_000,
  parameter int          GAP_QUARTERS = 4,
  parameter int          ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              sioc,
  output logic              siod_oe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] entry_cnt
);

  localparam int          QDIV       = CLK_FREQ_HZ / (4 * SCCB_FREQ_HZ);
  localparam int          QW         = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QLAST    = QW'(QDIV - 1);
  localparam logic [31:0] GAP_LAST   = (GAP_QUARTERS > 0) ? 32'(GAP_QUARTERS - 1) : 32'd0;
  localparam logic [31:0] DELAY_LAST = (DELAY_CYCLES > 0) ? 32'(DELAY_CYCLES - 1) : 32'd0;
  localparam logic [15:0] END_MARK   = 16'hFFFF;
  localparam logic [15:0] DELAY_MARK = 16'hFFF0;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BYTE, S_STOP, S_GAP, S_DELAY, S_DONE
  } state_t;

  state_t        state;
  logic [QW-1:0] qdiv_cnt;
  logic [1:0]    quarter;
  logic [4:0]    bit_idx;
  logic [26:0]   shift;
  logic [15:0]   entry;
  logic          fetch_wait;
  logic [31:0]   wait_cnt;
  logic          tick;
  logic          wait_over;

  assign tick      = (qdiv_cnt == QLAST);
  assign wait_over = (state == S_GAP)   ? (tick && wait_cnt >= GAP_LAST) :
                     (state == S_DELAY) ? (wait_cnt >= DELAY_LAST) : 1'b0;

  // NOTE: every register, including the bus pins, is updated with <= in this
  // one clocked block so each quarter's outputs appear together on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sioc       <= 1'b1;
      siod_oe    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rom_addr   <= '0;
      entry_cnt  <= '0;
      qdiv_cnt   <= '0;
      quarter    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      entry      <= '0;
      fetch_wait <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      if (state inside {S_START, S_BYTE, S_STOP, S_GAP})
        qdiv_cnt <= tick ? '0 : qdiv_cnt + QW'(1);

      case (state)
        S_IDLE, S_DONE: if (start) begin
          state      <= S_FETCH;
          rom_addr   <= '0;
          entry_cnt  <= '0;
          busy       <= 1'b1;
          done       <= 1'b0;
          fetch_wait <= 1'b1;
        end

        // The ROM answers one cycle after the address moves.
        S_FETCH: begin
          if (fetch_wait) fetch_wait <= 1'b0;
          else begin
            entry <= rom_data;
            state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (entry == END_MARK) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (entry == DELAY_MARK) begin
            state    <= S_DELAY;
            wait_cnt <= '0;
          end else begin
            state    <= S_START;
            qdiv_cnt <= '0;
            quarter  <= '0;
            shift    <= {DEV_ID, 1'b1, entry[15:8], 1'b1, entry[7:0], 1'b1};
            sioc     <= 1'b1;
            siod_oe  <= 1'b0;
          end
        end

        // Each case arm below sets the outputs of the quarter being entered.
        S_START: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: siod_oe <= 1'b1;
            2'd1: sioc    <= 1'b0;
            2'd3: begin
              state   <= S_BYTE;
              bit_idx <= '0;
              siod_oe <= ~shift[26];
            end
            default: ;
          endcase
        end

        S_BYTE: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd1: sioc <= 1'b1;
            2'd3: begin
              sioc <= 1'b0;
              if (bit_idx == 5'd26) begin
                state   <= S_STOP;
                siod_oe <= 1'b1;
              end else begin
                bit_idx <= bit_idx + 5'd1;
                shift   <= {shift[25:0], 1'b0};
                siod_oe <= ~shift[25];
              end
            end
            default: ;
          endcase
        end

        S_STOP: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: sioc    <= 1'b1;
            2'd1: siod_oe <= 1'b0;
            2'd3: begin
              entry_cnt <= entry_cnt + ADDR_W'(1);
              state     <= S_GAP;
              wait_cnt  <= '0;
            end
            default: ;
          endcase
        end

        S_GAP, S_DELAY: begin
          if (wait_over) begin
            if (rom_addr == {ADDR_W{1'b1}}) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              rom_addr   <= rom_addr + ADDR_W'(1);
              state      <= S_FETCH;
              fetch_wait <= 1'b1;
            end
          end else if (state == S_DELAY || tick) begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
